// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle 19-bit core: opcodes, ALU functions,
// FSM state codes and instruction field positions.
package mc_cpu_pkg;

    localparam int ILEN      = 19;
    localparam int OP_MSB    = 18;
    localparam int OP_LSB    = 15;
    localparam int RD_MSB    = 14;
    localparam int RD_LSB    = 11;
    localparam int RS1_MSB   = 10;
    localparam int RS1_LSB   = 7;
    localparam int RS2_MSB   = 6;
    localparam int RS2_LSB   = 3;
    localparam int FUNCT_MSB = 2;
    localparam int FUNCT_LSB = 0;
    localparam int ADDR11_W  = 11;
    localparam int BADDR_W   = 7;
    localparam int MADDR_W   = 8;

    typedef enum logic [3:0] {
        OP_ALU   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_BEQ   = 4'h3,
        OP_BNE   = 4'h4,
        OP_JMP   = 4'h5,
        OP_CALL  = 4'h6,
        OP_RET   = 4'h7,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        FN_ADD  = 3'd0,
        FN_SUB  = 3'd1,
        FN_AND  = 3'd2,
        FN_OR   = 3'd3,
        FN_XOR  = 3'd4,
        FN_SHL1 = 3'd5,
        FN_SHR1 = 3'd6,
        FN_SLT  = 3'd7
    } funct_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/mc_cpu_call_stack.sv
// Bounded LIFO of return addresses for CALL/RET; the core never pushes
// and pops in the same cycle, and it checks full/empty before asking.
module call_stack #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] top
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   SP_ONE  = 1;
    localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = 1;

    logic [AW:0]     sp_q;
    logic [AW:0]     sp_d;
    logic [AW-1:0]   top_idx;
    logic [PC_W-1:0] mem_q [DEPTH];

    assign full    = (sp_q == SP_FULL);
    assign empty   = (sp_q == '0);
    assign top_idx = sp_q[AW-1:0] - IDX_ONE;
    assign top     = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_ONE;
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            if (push && !full) begin
                mem_q[sp_q[AW-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle 19-bit core: FETCH/DECODE/EXEC/MEM/WB sequencer with an inline
// register file and ALU, req/ack instruction and data ports, and a call stack.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int XLEN        = 19,
    parameter int NREGS       = 16,
    parameter int PC_W        = 11,
    parameter int DADDR_W     = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [ILEN-1:0]    imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               retired,
    output logic               halted,
    output logic               err
);

    localparam logic [PC_W-1:0] PC_ONE = 1;
    localparam logic [XLEN-1:0] X_ONE  = 1;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [ILEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] c_q, c_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic            retired_q, retired_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] regs_q [16];

    opcode_e         op;
    logic [3:0]      rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_val, rs2_val, rd_val;
    logic [XLEN-1:0] alu_res;
    logic [PC_W-1:0] pc_inc, jump_target, branch_target;
    logic            fetch_req;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;

    // Address fields are zero-extended or truncated to the target width.
    function automatic logic [PC_W-1:0] to_pc(input logic [ADDR11_W-1:0] v);
        logic [PC_W-1:0] r;
        r = '0;
        for (int i = 0; i < PC_W && i < ADDR11_W; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    function automatic logic [DADDR_W-1:0] to_daddr(input logic [MADDR_W-1:0] v);
        logic [DADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < DADDR_W && i < MADDR_W; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    assign op            = opcode_e'(ir_q[OP_MSB:OP_LSB]);
    assign rd_idx        = ir_q[RD_MSB:RD_LSB];
    assign rs1_idx       = ir_q[RS1_MSB:RS1_LSB];
    assign rs2_idx       = ir_q[RS2_MSB:RS2_LSB];
    assign pc_inc        = pc_q + PC_ONE;
    assign jump_target   = to_pc(ir_q[ADDR11_W-1:0]);
    assign branch_target = to_pc({4'b0000, ir_q[BADDR_W-1:0]});

    assign rs1_val = (rs1_idx != 4'd0 && int'(rs1_idx) < NREGS) ? regs_q[rs1_idx] : '0;
    assign rs2_val = (rs2_idx != 4'd0 && int'(rs2_idx) < NREGS) ? regs_q[rs2_idx] : '0;
    assign rd_val  = (rd_idx  != 4'd0 && int'(rd_idx)  < NREGS) ? regs_q[rd_idx]  : '0;

    always_comb begin
        alu_res = '0;
        case (funct_e'(ir_q[FUNCT_MSB:FUNCT_LSB]))
            FN_ADD:  alu_res = a_q + b_q;
            FN_SUB:  alu_res = a_q - b_q;
            FN_AND:  alu_res = a_q & b_q;
            FN_OR:   alu_res = a_q | b_q;
            FN_XOR:  alu_res = a_q ^ b_q;
            FN_SHL1: alu_res = a_q << 1;
            FN_SHR1: alu_res = a_q >> 1;
            FN_SLT:  alu_res = (a_q < b_q) ? X_ONE : '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        mdr_d     = mdr_q;
        retired_d = 1'b0;
        err_d     = err_q;
        fetch_req = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = alu_res;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = rs1_val;
                b_d     = rs2_val;
                c_d     = rd_val;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d   = ST_FETCH;
                pc_d      = pc_inc;
                retired_d = 1'b1;
                case (op)
                    OP_ALU: rf_we = 1'b1;
                    OP_LOAD, OP_STORE: begin
                        retired_d = 1'b0;
                        state_d   = ST_MEM;
                    end
                    OP_BEQ: if (c_q == a_q) pc_d = branch_target;
                    OP_BNE: if (c_q != a_q) pc_d = branch_target;
                    OP_JMP: pc_d = jump_target;
                    OP_CALL: begin
                        if (stk_full) begin
                            pc_d      = pc_q;
                            retired_d = 1'b0;
                            err_d     = 1'b1;
                            state_d   = ST_HALT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = jump_target;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            pc_d      = pc_q;
                            retired_d = 1'b0;
                            err_d     = 1'b1;
                            state_d   = ST_HALT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end
                    end
                    OP_HALT: begin
                        pc_d      = pc_q;
                        retired_d = 1'b0;
                        state_d   = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STORE);
                if (dmem_ack) begin
                    if (op == OP_STORE) begin
                        retired_d = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                rf_wdata  = mdr_q;
                retired_d = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            mdr_q     <= '0;
            retired_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            mdr_q     <= mdr_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    // r0 and any index at or beyond NREGS are never written, so they read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && rd_idx != 4'd0 && int'(rd_idx) < NREGS) begin
            regs_q[rd_idx] <= rf_wdata;
        end
    end

    call_stack #(
        .DEPTH (STACK_DEPTH),
        .PC_W  (PC_W)
    ) u_call_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    // Gating with reset drops the fetch request the moment reset asserts.
    assign imem_req   = fetch_req & reset;
    assign imem_addr  = pc_q;
    assign dmem_addr  = to_daddr(ir_q[MADDR_W-1:0]);
    assign dmem_wdata = c_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign retired    = retired_q;
    assign halted     = (state_q == ST_HALT);
    assign err        = err_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Scoreboard bench for mc_cpu: directed programs, expected retirements and
// stores are queued at issue and checked by independent monitors.
module tb_mc_cpu;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ack;
    logic [18:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [18:0] dmem_wdata;
    logic        dmem_ack;
    logic [18:0] dmem_rdata;
    logic [10:0] pc;
    logic [2:0]  state;
    logic        retired;
    logic        halted;
    logic        err;

    typedef struct {
        int          gap;
        logic [10:0] pc;
    } ret_exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [18:0] data;
    } st_exp_t;

    ret_exp_t    ret_q[$];
    st_exp_t     st_q[$];
    logic [18:0] imem [2048];
    logic [18:0] dmem [256];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_ret = 0;
    int          cyc = 0;
    int          last_cyc = -1;
    int          dwait = 0;
    int          dcnt = 0;

    localparam logic [18:0] HALT_I = {4'hF, 15'h0};
    localparam logic [18:0] NOP_I  = {4'h8, 15'h0};
    localparam logic [18:0] RET_I  = {4'h7, 15'h0};

    mc_cpu #(
        .XLEN(19), .NREGS(16), .PC_W(11), .DADDR_W(8), .STACK_DEPTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .state      (state),
        .retired    (retired),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Zero-wait instruction memory; data memory acks after dwait wait cycles.
    assign imem_ack   = imem_req;
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt >= dwait);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else dcnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] = dmem_wdata;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Retirement monitor: pc after each retire and cycles since the previous one.
    always @(negedge clk) begin
        ret_exp_t e;
        if (reset === 1'b1 && retired === 1'b1) begin
            n_ret++;
            if (ret_q.size() > 0) begin
                e = ret_q.pop_front();
                check_output("retire_pc", 32'(pc), 32'(e.pc));
                if (e.gap >= 0) check_output("retire_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
        end
    end

    // Store monitor: every completed store must match the next queued one.
    always @(negedge clk) begin
        st_exp_t s;
        if (reset === 1'b1 && dmem_req === 1'b1 && dmem_we === 1'b1 && dmem_ack === 1'b1) begin
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check_output("store_addr", 32'(dmem_addr), 32'(s.addr));
                check_output("store_data", 32'(dmem_wdata), 32'(s.data));
            end else begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_store: got addr 0x%0h data 0x%0h, expected none", dmem_addr, dmem_wdata);
            end
        end
    end

    function automatic logic [18:0] enc_alu(input logic [3:0] rd, input logic [3:0] rs1,
                                            input logic [3:0] rs2, input logic [2:0] fn);
        return {4'h0, rd, rs1, rs2, fn};
    endfunction

    function automatic logic [18:0] enc_mem(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] a);
        return {op, rd, 3'b000, a};
    endfunction

    function automatic logic [18:0] enc_br(input logic [3:0] op, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [6:0] t);
        return {op, ra, rb, t};
    endfunction

    function automatic logic [18:0] enc_jmp(input logic [3:0] op, input logic [10:0] t);
        return {op, 4'h0, t};
    endfunction

    task automatic push_ret(input int gap, input logic [10:0] npc);
        ret_exp_t e;
        e.gap = gap;
        e.pc  = npc;
        ret_q.push_back(e);
    endtask

    task automatic push_store(input logic [7:0] a, input logic [18:0] d);
        st_exp_t s;
        s.addr = a;
        s.data = d;
        st_q.push_back(s);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        ret_q.delete();
        st_q.delete();
        dwait    = 0;
        last_cyc = -1;
        n_ret    = 0;
        for (int i = 0; i < 2048; i++) imem[i] = HALT_I;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        @(negedge clk);
    endtask

    task automatic apply_stimulus();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n;
        n = 0;
        while ((ret_q.size() != 0 || st_q.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (ret_q.size() != 0 || st_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got %0d pending, expected 0", name, ret_q.size() + st_q.size());
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  a_rd  [10];
        logic [3:0]  a_rs1 [10];
        logic [3:0]  a_rs2 [10];
        logic [2:0]  a_fn  [10];
        logic [18:0] a_exp [10];
        int          k;

        reset = 1'b0;
        apply_reset();
        #1;
        check_output("rst_pc", 32'(pc), 32'h0);
        check_output("rst_state", 32'(state), 32'h0);
        check_output("rst_imem_req", 32'(imem_req), 32'h0);
        check_output("rst_dmem_req", 32'(dmem_req), 32'h0);
        check_output("rst_retired", 32'(retired), 32'h0);
        check_output("rst_halted", 32'(halted), 32'h0);
        check_output("rst_err", 32'(err), 32'h0);

        // ALU: r1=5, r2=3 loaded, every funct exercised, results stored out
        $display("[TB] ALU program");
        a_rd  = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
        a_rs1 = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        a_rs2 = '{4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd2, 4'd2};
        a_fn  = '{3'd0, 3'd1, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        a_exp = '{19'd8, 19'h7FFFE, 19'd1, 19'd1, 19'd7, 19'd6, 19'd10, 19'd2, 19'd0, 19'd0};
        apply_reset();
        dmem[0] = 19'd5;
        dmem[1] = 19'd3;
        imem[0] = enc_mem(4'h1, 4'd1, 8'h00);
        imem[1] = enc_mem(4'h1, 4'd2, 8'h01);
        push_ret(-1, 11'd1);
        push_ret(5, 11'd2);
        for (int i = 0; i < 10; i++) begin
            imem[2 + i] = enc_alu(a_rd[i], a_rs1[i], a_rs2[i], a_fn[i]);
            push_ret(3, 11'(3 + i));
        end
        for (int i = 0; i < 10; i++) begin
            imem[12 + i] = enc_mem(4'h2, a_rd[i], 8'(8'h20 + i));
            push_ret(4, 11'(13 + i));
            push_store(8'(8'h20 + i), a_exp[i]);
        end
        apply_stimulus();
        wait_drain(200, "alu");
        wait_cycles(6);
        check_output("alu_halted", 32'(halted), 32'h1);
        check_output("alu_state", 32'(state), 32'h5);
        check_output("alu_err", 32'(err), 32'h0);

        // Wait-state data memory: LOAD takes 5+4, STORE 4+4 cycles
        $display("[TB] memory wait states");
        apply_reset();
        dwait = 4;
        dmem[8'h10] = 19'h12345;
        imem[0] = NOP_I;
        imem[1] = enc_mem(4'h1, 4'd1, 8'h10);
        imem[2] = enc_mem(4'h2, 4'd1, 8'h11);
        push_ret(-1, 11'd1);
        push_ret(9, 11'd2);
        push_ret(8, 11'd3);
        push_store(8'h11, 19'h12345);
        apply_stimulus();
        wait_drain(100, "mem");
        check_output("mem_dmem11", 32'(dmem[8'h11]), 32'h12345);

        // Branches and JMP with PC wrap from 0x7FF to 0
        $display("[TB] branches");
        apply_reset();
        dmem[0] = 19'd5;
        imem[11'h000] = enc_br(4'h3, 4'd0, 4'd0, 7'h20);
        imem[11'h020] = enc_br(4'h4, 4'd0, 4'd0, 7'h50);
        imem[11'h021] = enc_mem(4'h1, 4'd1, 8'h00);
        imem[11'h022] = enc_br(4'h3, 4'd1, 4'd0, 7'h40);
        imem[11'h023] = enc_br(4'h4, 4'd1, 4'd0, 7'h30);
        imem[11'h030] = enc_jmp(4'h5, 11'h7FF);
        imem[11'h7FF] = NOP_I;
        push_ret(-1, 11'h020);
        push_ret(3, 11'h021);
        push_ret(5, 11'h022);
        push_ret(3, 11'h023);
        push_ret(3, 11'h030);
        push_ret(3, 11'h7FF);
        push_ret(3, 11'h000);
        apply_stimulus();
        wait_drain(100, "branch");

        // Eight nested calls and returns, then a ninth call overflows
        $display("[TB] call nesting");
        apply_reset();
        for (k = 0; k < 8; k++) begin
            imem[11'(k * 11'h080)] = enc_jmp(4'h6, 11'((k + 1) * 11'h080));
            push_ret(k == 0 ? -1 : 3, 11'((k + 1) * 11'h080));
        end
        imem[11'h400] = RET_I;
        for (k = 1; k < 8; k++) imem[11'(k * 11'h080 + 1)] = RET_I;
        for (k = 7; k >= 0; k--) push_ret(3, 11'(k * 11'h080 + 1));
        imem[11'h001] = enc_jmp(4'h6, 11'h500);
        push_ret(3, 11'h500);
        for (k = 0; k < 8; k++) imem[11'(11'h500 + k * 11'h020)] = enc_jmp(4'h6, 11'(11'h520 + k * 11'h020));
        for (k = 0; k < 7; k++) push_ret(3, 11'(11'h520 + k * 11'h020));
        apply_stimulus();
        wait_drain(300, "call");
        wait_cycles(6);
        check_output("ovf_err", 32'(err), 32'h1);
        check_output("ovf_halted", 32'(halted), 32'h1);
        check_output("ovf_state", 32'(state), 32'h5);
        check_output("ovf_pc", 32'(pc), 32'h5E0);
        check_output("ovf_imem_req", 32'(imem_req), 32'h0);
        wait_cycles(5);
        check_output("ovf_pc_frozen", 32'(pc), 32'h5E0);

        // RET with an empty stack straight out of reset
        $display("[TB] return underflow");
        apply_reset();
        imem[0] = RET_I;
        apply_stimulus();
        wait_cycles(8);
        check_output("unf_err", 32'(err), 32'h1);
        check_output("unf_state", 32'(state), 32'h5);
        check_output("unf_imem_req", 32'(imem_req), 32'h0);
        check_output("unf_pc", 32'(pc), 32'h0);
        check_output("unf_retired_count", 32'(n_ret), 32'h0);

        // Reset asserted mid-handshake in MEM, then clean restart from 0
        $display("[TB] reset during MEM");
        apply_reset();
        dwait = 20;
        dmem[8'h10] = 19'h0ABCD;
        imem[0] = enc_mem(4'h1, 4'd1, 8'h10);
        imem[1] = enc_mem(4'h2, 4'd1, 8'h12);
        apply_stimulus();
        k = 0;
        while (dmem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_output("midrst_dmem_req_seen", 32'(dmem_req), 32'h1);
        wait_cycles(2);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_dmem_req", 32'(dmem_req), 32'h0);
        check_output("midrst_pc", 32'(pc), 32'h0);
        check_output("midrst_state", 32'(state), 32'h0);
        check_output("midrst_imem_req", 32'(imem_req), 32'h0);
        check_output("midrst_dmem_we", 32'(dmem_we), 32'h0);
        apply_reset();
        dmem[8'h10] = 19'h0ABCD;
        imem[0] = enc_mem(4'h1, 4'd1, 8'h10);
        imem[1] = enc_mem(4'h2, 4'd1, 8'h12);
        push_ret(-1, 11'd1);
        push_ret(4, 11'd2);
        push_store(8'h12, 19'h0ABCD);
        apply_stimulus();
        wait_drain(100, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_cpu.md
# mc_cpu

Parametrised multi-cycle successor to the single-cycle 19-bit core. It executes the same 19-bit fixed-format instruction stream through a FETCH/DECODE/EXEC/MEM/WB state machine, with XLEN-wide data and a bounded hardware call stack. Instruction and data memories sit outside the block behind req/ack handshakes, so wait-state memories are supported. The block replaces the top-level core; the testbench and SoC wrapper drive it.

## Interface
Parameters:
- XLEN, 19, data/register width (≥8)
- NREGS, 16, register count (≤16; r0 reads zero, writes ignored)
- PC_W, 11, program counter width
- DADDR_W, 8, data address width
- STACK_DEPTH, 8, call-stack entries (power of 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- imem_req  out  1  fetch request; held until ack
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  19  instruction
- dmem_req  out  1  data request; held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  DADDR_W  data address
- dmem_wdata  out  XLEN  store data
- dmem_ack  in  1  access complete; dmem_rdata valid on loads
- dmem_rdata  in  XLEN  load data
- pc  out  PC_W  current PC
- state  out  3  FSM state code
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped
- err  out  1  stack overflow/underflow occurred

## Operation
- Format: op[18:15], rd[14:11], rs1[10:7], rs2[6:3], funct[2:0]; addr11 = [10:0]; baddr7 = [6:0]; maddr = [7:0].
- ALU (0000): rd ← rs1 op rs2. funct: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 SLT (unsigned, result 0/1). Results are modulo 2^XLEN.
- LOAD (0001): rd ← mem[maddr]. STORE (0010): mem[maddr] ← reg[rd]. maddr is zero-extended or truncated to DADDR_W.
- BEQ (0011) / BNE (0100): compare reg[rd] with reg[rs1]; if taken, pc ← baddr7 zero-extended; otherwise pc+1.
- JMP (0101): pc ← addr11. CALL (0110): push pc+1, then pc ← addr11. RET (0111): pc ← pop.
- HALT (1111): halted=1. All other opcodes execute as NOP.
- Stack error: CALL with stack full or RET with stack empty → no push/pop, err=1, halted=1.
- PC arithmetic wraps modulo 2^PC_W.

## Timing
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5).
- FETCH: imem_req=1. On a clock edge where imem_ack=1, latch IR and go to DECODE.
- DECODE: register operands are latched. Next state is always EXEC.
- EXEC: ALU ops write rd, branches/jumps/calls/rets update pc, NOPs do nothing; each then sets retired and goes to FETCH. LOAD/STORE go to MEM. HALT or a stack error goes to HALT.
- MEM: dmem_req=1, with addr/we/wdata stable until ack. On ack, LOAD goes to WB; STORE sets retired and goes to FETCH.
- WB: rd ← latched dmem_rdata, retired=1, then FETCH.
- Zero-wait CPI: ALU/branch/jump/call/ret/NOP = 3, STORE = 4, LOAD = 5. Each wait cycle adds one.
- HALT state is absorbing until reset: no requests, pc frozen.
- Reset (async assert, any state, including mid-handshake): all registers, pc, sp, and outputs are 0; state=FETCH; req lines drop immediately. The first fetch is at pc 0 on the first edge after deassertion.
- retired is 0 in every cycle where its conditions above are not met.

## Structure
- Package mc_cpu_pkg: opcode enum, ALU funct enum, state enum with the codes above, field-position constants.
- Sub-module call_stack (params DEPTH, PC_W): push/pop/full/empty/top. A push and pop in the same cycle cannot occur. Async active-low reset.
- Register file and ALU stay inline.

## Test plan
- ALU: r1=5, r2=3 (loaded); ADD r3,r1,r2 → r3=8; SUB r4,r2,r1 → r4=2^XLEN−2; SLT r5,r2,r1 → 1; retired pulses 3 cycles apart.
- Memory wait states: LOAD r1,[0x10] with dmem_ack delayed 4 cycles → dmem_req held 4 cycles, r1=mem value, instruction takes 9 cycles; STORE r1,[0x11] → mem[0x11] equals r1.
- Branches: BEQ with equal regs, target 0x20 → pc=0x20; BNE with equal regs → pc+1; JMP 0x7FF then NOP → pc wraps to 0.
- Call nesting: 8 nested CALLs then 8 RETs → each returns to its call site+1; a 9th CALL → err=1, halted=1, pc frozen.
- RET on empty stack at reset → err=1, state=HALT, no imem_req afterwards.
- Reset asserted during MEM with dmem_req=1 → dmem_req=0 in the same cycle, pc=0, state=FETCH; execution resumes at 0 after release.
